deflect_port_alloc: RTL
=======================

Name: deflect_port_alloc

Overview:
- Per-router output port allocator for the bufferless deflection router.
- Consumes the productive vectors produced by the four per-input route-computation units (N/E/S/W) and assigns every valid flit exactly one distinct output port.
- Losers of port conflicts are deflected to any free network port.
- Sits between the route-computation stage and the crossbar; the result is registered, so one pipeline stage.

Parameters:
- NUM_IN, 4, network input ports; only 4 is supported.
- WIDTH_PORT, 5, productive-vector and port-select width (`NUM_PORT).
- STAT_WIDTH, 16, deflection-counter width (optional feature only).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  4  bit i: input i holds a flit this cycle
- in_golden  input  4  bit i: flit i is golden (highest priority)
- in_prod  input  20  productive vector of input i at [5i+4:5i]; bit0 W, bit1 E, bit2 S, bit3 N, bit4 local
- out_valid  output  4  registered copy of in_valid
- out_port  output  20  one-hot grant for input i at [5i+4:5i], same bit mapping as in_prod
- out_deflect  output  4  bit i: input i received a non-productive port
- rr_ptr  output  2  current round-robin start index (debug)

Behaviour:
- Reset (reset=1 at posedge): out_valid=0, out_port=0, out_deflect=0, rr_ptr=0; counters cleared when the optional feature is present.
- Latency: grants for the inputs sampled at edge k appear on the outputs after edge k, i.e. 1 cycle.
- No stall or backpressure: every valid flit must be granted every cycle.
- Invalid inputs get out_port slice = 0 and out_deflect bit = 0. Their in_prod is ignored.
- Service order, computed combinationally each cycle:
  - First pass: golden valid inputs, starting at rr_ptr and ascending mod 4.
  - Second pass: non-golden valid inputs, in the same rotation.
- Each serviced input takes the first rule that applies:
  - (a) Local (bit4), if in_prod bit4=1 and local is not yet taken. At most one ejection per cycle.
  - (b) Else the lowest-indexed free network port among in_prod[3:0] bits.
  - (c) Else the lowest-indexed free network port of all four, and out_deflect=1.
- Allocation is always possible: at most 4 flits and 4 network ports. Out-of-range productive bits are still honoured. An all-zero in_prod on a valid input falls to rule (c) and is flagged as a deflection.
- Grants are one-hot per input and pairwise disjoint. No network port or local port is granted twice in a cycle.
- rr_ptr advances by 1 mod 4 (3 wraps to 0) at each edge where in_valid != 0. It holds otherwise.
- Reset asserted mid-operation: the next-cycle outputs are 0 regardless of inputs. Flits in flight are dropped; upstream retransmission owns recovery.

Optional Feature:
- Macro: DEFLECT_STATS_EN.
- Defined:
  - Adds output deflect_cnt[STAT_WIDTH-1:0] and output eject_cnt[STAT_WIDTH-1:0].
  - At each edge, deflect_cnt increments by popcount of the new out_deflect and eject_cnt increments by 1 if any local grant is made.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: the ports and logic are absent; allocation behaviour is identical.

Test Plan:
- Single flit: reset, then in_valid=0001, in_prod[4:0]=00100 → next cycle out_port[4:0]=00100, out_deflect=0000, rr_ptr=1.
- North conflict: rr_ptr=0, in_valid=0011, both in_prod=01000, golden=0000 → input0 gets 01000, input1 gets 00001, out_deflect=0010.
- Golden override: same stimulus with in_golden=0010 → input1 gets 01000, input0 gets 00001, out_deflect=0001.
- Ejection contention: rr_ptr=2, in_valid=1100, in_prod2=in_prod3=10000 → input2 gets 10000, input3 gets 00001, out_deflect=1000. With DEFLECT_STATS_EN: deflect_cnt=1, eject_cnt=1.
- Full load plus wrap:
  - Stimulus: 4 valid flits all prod 00010 for 4 consecutive cycles.
  - Response: each cycle exactly one granted 00010, the other three get 00001/00100/01000 distinctly.
  - rr_ptr sequence: 0→1→2→3→0.
- Reset mid-stream: assert reset during the full-load test → next cycle out_valid=0, out_port=0, rr_ptr=0, counters=0.

Source files
------------

// File: rtl/deflect_port_alloc.sv
// deflect_port_alloc: one-stage output port allocator for a bufferless deflection router.
//
// Every valid flit is granted exactly one distinct output port each cycle.
// Golden flits are served before non-golden ones, each group in round-robin
// order starting at rr_ptr. A flit that cannot get a productive port is
// deflected to a free network port.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_valid     per-input flit valid
//   in_golden    per-input golden (priority) flag
//   in_prod      per-input productive vector, [5i+4:5i] = {L,N,S,E,W}
//   out_valid    registered in_valid
//   out_port     per-input one-hot grant, same bit mapping as in_prod
//   out_deflect  per-input flag: granted port was not productive
//   rr_ptr       round-robin start index
//   deflect_cnt  saturating deflection count  (DEFLECT_STATS_EN only)
//   eject_cnt    saturating ejection count    (DEFLECT_STATS_EN only)
//
// Define DEFLECT_STATS_EN to add the deflection/ejection counters.
module deflect_port_alloc #(
    parameter int NUM_IN     = 4,
    parameter int WIDTH_PORT = 5
`ifdef DEFLECT_STATS_EN
    , parameter int STAT_WIDTH = 16
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN-1:0]            in_golden,
    input  logic [NUM_IN*WIDTH_PORT-1:0] in_prod,
    output logic [NUM_IN-1:0]            out_valid,
    output logic [NUM_IN*WIDTH_PORT-1:0] out_port,
    output logic [NUM_IN-1:0]            out_deflect,
`ifdef DEFLECT_STATS_EN
    output logic [1:0]                   rr_ptr,
    output logic [STAT_WIDTH-1:0]        deflect_cnt,
    output logic [STAT_WIDTH-1:0]        eject_cnt
`else
    output logic [1:0]                   rr_ptr
`endif
);

    logic [NUM_IN-1:0][WIDTH_PORT-1:0] prod_a;
    logic [NUM_IN-1:0][WIDTH_PORT-1:0] port_d, port_q;
    logic [NUM_IN-1:0]                 defl_d, defl_q, valid_q;
    logic [1:0]                        rr_q, idx;
    logic [3:0]                        net_free, avail;
    logic [WIDTH_PORT-1:0]             prod, grant;
    logic                              eject_d;

    assign prod_a      = in_prod;
    assign out_valid   = valid_q;
    assign out_port    = port_q;
    assign out_deflect = defl_q;
    assign rr_ptr      = rr_q;

    // Two passes (golden, then non-golden) over the rotated input order.
    // net_free shrinks as network ports are handed out; eject_d marks the
    // single local port as taken.
    always_comb begin
        net_free = 4'b1111;
        eject_d  = 1'b0;
        port_d   = '0;
        defl_d   = '0;
        idx      = '0;
        prod     = '0;
        grant    = '0;
        avail    = '0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = rr_q + 2'(k);
                if (in_valid[idx] && (in_golden[idx] == (p == 0))) begin
                    prod  = prod_a[idx];
                    avail = prod[3:0] & net_free;
                    if (prod[4] && !eject_d) begin
                        grant   = 5'b10000;
                        eject_d = 1'b1;
                    end else begin
                        // x & -x isolates the lowest set bit
                        grant       = {1'b0, (avail != 4'b0) ? (avail & -avail) : (net_free & -net_free)};
                        defl_d[idx] = (avail == 4'b0);
                        net_free    = net_free & ~grant[3:0];
                    end
                    port_d[idx] = grant;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            port_q  <= '0;
            defl_q  <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= in_valid;
            port_q  <= port_d;
            defl_q  <= defl_d;
            rr_q    <= rr_q + 2'(|in_valid);
        end
    end

`ifdef DEFLECT_STATS_EN
    logic [STAT_WIDTH-1:0] dcnt_q, dcnt_d, ecnt_q, ecnt_d;
    logic [STAT_WIDTH:0]   dsum;

    assign deflect_cnt = dcnt_q;
    assign eject_cnt   = ecnt_q;

    // Add in one extra bit so a carry out means saturate.
    always_comb begin
        dsum   = {1'b0, dcnt_q} + (STAT_WIDTH+1)'($countones(defl_d));
        dcnt_d = dsum[STAT_WIDTH] ? '1 : dsum[STAT_WIDTH-1:0];
        ecnt_d = (eject_d && (ecnt_q != '1)) ? ecnt_q + 1'b1 : ecnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            ecnt_q <= ecnt_d;
        end
    end
`endif

endmodule
